// File: rtl/spi_nor_flash_model.sv
// Behavioural SPI NOR flash (W25Q-style subset) clocked entirely by clk.
// csn/sck/mosi are oversampled through 2-flop synchronizers; the SPI bus
// is mode 0 and must run at clk/8 or slower.
module spi_nor_flash_model #(
  parameter int unsigned MEM_AW      = 16,
  parameter int unsigned BUSY_CYCLES = 64,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic clk,
  input  logic rst,
  input  logic csn,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  input  logic wp_n,
  input  logic hold_n
);

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_SE    = 8'h20;

  localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_IN, DATA_OUT, IGNORE} state_t;

  // Array powers up erased; rst deliberately leaves it alone.
  logic [7:0] mem [0:(1<<MEM_AW)-1] = '{default: 8'hFF};

  logic              csn_s1, csn_s2, csn_d;
  logic              sck_s1, sck_s2, sck_d;
  logic              mosi_s1, mosi_s2;
  logic              csn_fall, csn_rise, sck_rise, sck_fall;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [1:0]        ab_cnt;
  logic [6:0]        shift_in;
  logic [7:0]        opcode;
  logic [MEM_AW-1:0] addr;
  logic [7:0]        out_byte;
  logic [1:0]        id_idx;
  logic              wel, busy, erasing;
  logic [15:0]       busy_cnt;
  logic              extra;
  logic              pp_any;

  logic [7:0]        byte_in;
  logic [7:0]        sr1;
  logic [MEM_AW-1:0] addr_shift;
  logic [MEM_AW-1:0] addr_inc;
  logic [MEM_AW-1:0] page_inc;
  logic [1:0]        id_nxt;
  logic              pp_wr;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_wa;
  logic [7:0]        mem_wd;

  logic unused_pins;
  assign unused_pins = wp_n & hold_n;

  function automatic logic [7:0] id_byte(input logic [1:0] i);
    case (i)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      default: return JEDEC_ID[7:0];
    endcase
  endfunction

  // Synchronizers run through reset so edges are never invented after rst drops.
  always_ff @(posedge clk) begin
    csn_s1  <= csn;
    csn_s2  <= csn_s1;
    csn_d   <= csn_s2;
    sck_s1  <= sck;
    sck_s2  <= sck_s1;
    sck_d   <= sck_s2;
    mosi_s1 <= mosi;
    mosi_s2 <= mosi_s1;
  end

  assign csn_fall   = ~csn_s2 & csn_d;
  assign csn_rise   = csn_s2 & ~csn_d;
  assign sck_rise   = sck_s2 & ~sck_d;
  assign sck_fall   = ~sck_s2 & sck_d;
  assign miso_oe    = ~csn_s2 & ~rst;

  assign byte_in    = {shift_in, mosi_s2};
  assign sr1        = {6'b0, wel, busy};
  assign addr_shift = {addr[MEM_AW-2:0], mosi_s2};
  assign addr_inc   = addr + ADDR_ONE;
  assign page_inc   = {addr[MEM_AW-1:8], addr[7:0] + 8'd1};
  assign id_nxt     = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;

  assign pp_wr = ~csn_s2 & sck_rise & (state == DATA_IN) &
                 (opcode == OP_PP) & (bit_cnt == 3'd7);

  // Single write port shared by sector erase and page program (never concurrent).
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!rst) begin
      if (erasing) begin
        mem_we = 1'b1;
        mem_wa = {addr[MEM_AW-1:12], busy_cnt[11:0]};
        mem_wd = 8'hFF;
      end else if (pp_wr) begin
        mem_we = 1'b1;
        mem_wa = addr;
        mem_wd = mem[addr] & byte_in;
      end
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Transaction FSM, status register and busy/erase timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      ab_cnt   <= '0;
      shift_in <= '0;
      opcode   <= '0;
      addr     <= '0;
      out_byte <= '0;
      id_idx   <= '0;
      wel      <= 1'b0;
      busy     <= 1'b0;
      erasing  <= 1'b0;
      busy_cnt <= '0;
      extra    <= 1'b0;
      pp_any   <= 1'b0;
      miso     <= 1'b0;
    end else begin
      if (busy) begin
        busy_cnt <= busy_cnt + 16'd1;
        if (erasing ? (busy_cnt[11:0] == 12'hFFF)
                    : (busy_cnt == 16'(BUSY_CYCLES - 1))) begin
          busy    <= 1'b0;
          erasing <= 1'b0;
          wel     <= 1'b0;
        end
      end

      if (csn_s2) begin
        state <= IDLE;
        miso  <= 1'b0;
        // DATA_IN is only reachable after a complete opcode (and address where needed).
        if (csn_rise && state == DATA_IN) begin
          case (opcode)
            OP_WREN: if (!extra) wel <= 1'b1;
            OP_WRDI: if (!extra) wel <= 1'b0;
            OP_SE: if (!extra) begin
              busy     <= 1'b1;
              erasing  <= 1'b1;
              busy_cnt <= '0;
            end
            OP_PP: if (pp_any) begin
              busy     <= 1'b1;
              busy_cnt <= '0;
            end
            default: ;
          endcase
        end
      end else if (csn_fall) begin
        state   <= CMD;
        bit_cnt <= '0;
        extra   <= 1'b0;
        pp_any  <= 1'b0;
        miso    <= 1'b0;
      end else begin
        if (state != DATA_OUT) miso <= 1'b0;
        else if (sck_fall)     miso <= out_byte[~bit_cnt];

        if (sck_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= byte_in[6:0];
          case (state)
            CMD: if (bit_cnt == 3'd7) begin
              opcode <= byte_in;
              ab_cnt <= '0;
              extra  <= 1'b0;
              if (busy && byte_in != OP_RDSR1) begin
                state <= IGNORE;
              end else begin
                case (byte_in)
                  OP_WREN, OP_WRDI: state <= DATA_IN;
                  OP_RDSR1: begin
                    state    <= DATA_OUT;
                    out_byte <= sr1;
                  end
                  OP_RDID: begin
                    state    <= DATA_OUT;
                    id_idx   <= 2'd0;
                    out_byte <= id_byte(2'd0);
                  end
                  OP_READ:      state <= ADDR;
                  OP_PP, OP_SE: state <= wel ? ADDR : IGNORE;
                  default:      state <= IGNORE;
                endcase
              end
            end
            ADDR: begin
              addr <= addr_shift;
              if (bit_cnt == 3'd7) begin
                ab_cnt <= ab_cnt + 2'd1;
                if (ab_cnt == 2'd2) begin
                  if (opcode == OP_READ) begin
                    state    <= DATA_OUT;
                    out_byte <= mem[addr_shift];
                  end else begin
                    state <= DATA_IN;
                  end
                end
              end
            end
            DATA_IN: begin
              extra <= 1'b1;
              if (bit_cnt == 3'd7 && opcode == OP_PP) begin
                addr   <= page_inc;
                pp_any <= 1'b1;
              end
            end
            DATA_OUT: if (bit_cnt == 3'd7) begin
              case (opcode)
                OP_RDSR1: out_byte <= sr1;
                OP_RDID: begin
                  id_idx   <= id_nxt;
                  out_byte <= id_byte(id_nxt);
                end
                default: begin
                  addr     <= addr_inc;
                  out_byte <= mem[addr_inc];
                end
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_nor_flash_model.sv
// Directed bench for spi_nor_flash_model: SPI mode 0 master at clk/10.
module tb_spi_nor_flash_model;

  logic clk = 1'b0;
  logic rst, csn, sck, mosi, miso, miso_oe, wp_n, hold_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_nor_flash_model #(
    .MEM_AW(16),
    .BUSY_CYCLES(300),
    .JEDEC_ID(24'hEF4018)
  ) dut (
    .clk(clk), .rst(rst), .csn(csn), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wp_n(wp_n), .hold_n(hold_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    csn = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    sck = 1'b0;
    wait_clk(5);
    csn = 1'b1;
    wait_clk(6);
  endtask

  task automatic xbits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      sck  = 1'b0;
      mosi = tx[i];
      wait_clk(5);
      rx[i] = miso;
      sck = 1'b1;
      wait_clk(5);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xbits(tx, 8, rx);
  endtask

  task automatic cmd1(input logic [7:0] op);
    logic [7:0] d;
    cs_low();
    xfer(op, d);
    cs_high();
  endtask

  task automatic rdsr(output logic [7:0] sr);
    logic [7:0] d;
    cs_low();
    xfer(8'h05, d);
    xfer(8'h00, sr);
    cs_high();
  endtask

  task automatic send_addr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    xfer(op, d);
    xfer(a[23:16], d);
    xfer(a[15:8], d);
    xfer(a[7:0], d);
  endtask

  task automatic pp(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [7:0] d;
    cs_low();
    send_addr(8'h02, a);
    xfer(b0, d);
    if (n > 1) xfer(b1, d);
    cs_high();
  endtask

  task automatic rd2(input logic [23:0] a, output logic [7:0] r0, output logic [7:0] r1);
    cs_low();
    send_addr(8'h03, a);
    xfer(8'h00, r0);
    xfer(8'h00, r1);
    cs_high();
  endtask

  initial begin
    logic [7:0] r0, r1, r2, sr;
    rst = 1'b1; csn = 1'b1; sck = 1'b0; mosi = 1'b0; wp_n = 1'b1; hold_n = 1'b1;
    wait_clk(6);
    rst = 1'b0;
    wait_clk(2);
    chk("reset_miso", 32'(miso), 32'h0);
    chk("reset_oe", 32'(miso_oe), 32'h0);

    // JEDEC ID, then the sequence repeats
    cs_low();
    chk("rdid_oe_on", 32'(miso_oe), 32'h1);
    xfer(8'h9F, r0);
    xfer(8'h00, r0); chk("rdid_b0", 32'(r0), 32'hEF);
    xfer(8'h00, r0); chk("rdid_b1", 32'(r0), 32'h40);
    xfer(8'h00, r0); chk("rdid_b2", 32'(r0), 32'h18);
    xfer(8'h00, r0); chk("rdid_rep", 32'(r0), 32'hEF);
    cs_high();
    chk("rdid_oe_off", 32'(miso_oe), 32'h0);

    rdsr(sr); chk("sr_init", 32'(sr), 32'h00);
    cmd1(8'h06);
    rdsr(sr); chk("sr_wel", 32'(sr), 32'h02);

    // Page program, status while busy, then read back
    pp(24'h000100, 8'h3C, 8'hA5, 2);
    cs_low();
    xfer(8'h05, r0);
    xfer(8'h00, r0);
    xfer(8'h00, r1);
    cs_high();
    chk("pp_busy0", 32'(r0 & 8'h01), 32'h1);
    chk("pp_busy1", 32'(r1 & 8'h01), 32'h1);
    wait_clk(400);
    rdsr(sr); chk("pp_done_sr", 32'(sr), 32'h00);
    cs_low();
    send_addr(8'h03, 24'h000100);
    xfer(8'h00, r0); xfer(8'h00, r1); xfer(8'h00, r2);
    cs_high();
    chk("read_b0", 32'(r0), 32'h3C);
    chk("read_b1", 32'(r1), 32'hA5);
    chk("read_b2", 32'(r2), 32'hFF);

    // Program without WEL is ignored
    pp(24'h000000, 8'h00, 8'h00, 1);
    rdsr(sr); chk("nowel_sr", 32'(sr), 32'h00);
    rd2(24'h000000, r0, r1); chk("nowel_mem", 32'(r0), 32'hFF);

    // Sector erase
    cmd1(8'h06);
    cs_low(); send_addr(8'h20, 24'h000123); cs_high();
    rdsr(sr); chk("se_busy", 32'(sr & 8'h01), 32'h1);
    wait_clk(4200);
    rd2(24'h000100, r0, r1);
    chk("se_b0", 32'(r0), 32'hFF);
    chk("se_b1", 32'(r1), 32'hFF);
    rdsr(sr); chk("se_sr", 32'(sr), 32'h00);

    // Column wrap inside a page
    cmd1(8'h06);
    pp(24'h0000FF, 8'h11, 8'h22, 2);
    wait_clk(400);
    rd2(24'h0000FF, r0, r1);
    chk("pw_ff", 32'(r0), 32'h11);
    chk("pw_100", 32'(r1), 32'hFF);
    rd2(24'h000000, r0, r1);
    chk("pw_00", 32'(r0), 32'h22);

    // Read wraps from array end to 0
    cmd1(8'h06);
    pp(24'h00FFFF, 8'h5A, 8'h00, 1);
    wait_clk(400);
    rd2(24'h00FFFF, r0, r1);
    chk("aw_ffff", 32'(r0), 32'h5A);
    chk("aw_0000", 32'(r1), 32'h22);

    // WREN with trailing bits does not count
    cs_low(); xfer(8'h06, r0); xbits(8'hFF, 4, r0); cs_high();
    rdsr(sr); chk("wren_extra", 32'(sr), 32'h00);

    // Partial data byte is discarded
    cmd1(8'h06);
    cs_low(); send_addr(8'h02, 24'h000200); xfer(8'h0F, r0); xbits(8'h00, 4, r0); cs_high();
    wait_clk(400);
    rd2(24'h000200, r0, r1);
    chk("part_b0", 32'(r0), 32'h0F);
    chk("part_b1", 32'(r1), 32'hFF);

    // WRDI clears WEL
    cmd1(8'h06);
    rdsr(sr); chk("wrdi_pre", 32'(sr), 32'h02);
    cmd1(8'h04);
    rdsr(sr); chk("wrdi_post", 32'(sr), 32'h00);

    // Commands other than RDSR1 are ignored while busy
    cmd1(8'h06);
    pp(24'h000300, 8'h77, 8'h00, 1);
    cs_low(); send_addr(8'h03, 24'h000300); xfer(8'h00, r0); cs_high();
    chk("busy_ign", 32'(r0), 32'h00);
    wait_clk(400);
    rd2(24'h000300, r0, r1);
    chk("busy_pp", 32'(r0), 32'h77);

    // Reset mid-transaction needs a fresh csn fall
    cs_low();
    xbits(8'h06, 4, r0);
    rst = 1'b1; wait_clk(3); rst = 1'b0;
    xfer(8'h06, r0);
    cs_high();
    rdsr(sr); chk("rst_nocmd", 32'(sr), 32'h00);
    cmd1(8'h06);
    rdsr(sr); chk("rst_fresh", 32'(sr), 32'h02);

    // Reset aborts an erase in progress
    cs_low(); send_addr(8'h20, 24'h001000); cs_high();
    wait_clk(50);
    rst = 1'b1; wait_clk(3); rst = 1'b0;
    wait_clk(2);
    rdsr(sr); chk("rst_abort", 32'(sr), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
